// File: rtl/sim_uart_in_feeder.sv
// Simulation UART input source: host pushes characters into a FIFO and the DUT pulls one per read strobe.
// Latency: strobe-to-data is combinational (0 cycles); a pushed char becomes deliverable 1 cycle later.
// Backpressure: push_ready drops when full (refused pushes are counted); optional UART_IN_PACING_EN spaces deliveries.
module sim_uart_in_feeder #(
  parameter int          DEPTH      = 16,
  parameter logic [7:0]  EMPTY_CHAR = 8'hff,
  parameter int          GAP_CYCLES = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_valid,
  input  logic [7:0]                 push_ch,
  output logic                       push_ready,
  input  logic                       uart_in_valid,
  output logic [7:0]                 uart_in_ch,
  output logic [$clog2(DEPTH):0]     level,
  output logic [31:0]                rd_count,
  output logic [31:0]                underrun_count,
  output logic [15:0]                push_drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   rd_count_q, rd_count_d;
  logic [31:0]   underrun_count_q, underrun_count_d;
  logic [15:0]   push_drop_count_q, push_drop_count_d;

  logic pace_ok;
  logic deliverable;
  logic push_acc;
  logic pop;

  // Full is judged on the registered level only, so a same-cycle pop never opens room for a push.
  assign push_ready  = (level_q != LW'(DEPTH));
  assign deliverable = (level_q != '0) && pace_ok;
  assign push_acc    = push_valid && push_ready;
  assign pop         = uart_in_valid && deliverable;
  assign uart_in_ch  = deliverable ? mem_q[rd_ptr_q] : EMPTY_CHAR;

  assign level           = level_q;
  assign rd_count        = rd_count_q;
  assign underrun_count  = underrun_count_q;
  assign push_drop_count = push_drop_count_q;

`ifdef UART_IN_PACING_EN
  logic [7:0] pace_q, pace_d;

  // Pace counter: reload on every delivery, then count down to re-enable the next one.
  always_comb begin
    pace_d = pace_q;
    if (pop) begin
      pace_d = 8'(GAP_CYCLES);
    end else if (pace_q != 8'd0) begin
      pace_d = pace_q - 8'd1;
    end
  end

  // Pace counter register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pace_q <= 8'd0;
    end else begin
      pace_q <= pace_d;
    end
  end

  assign pace_ok = (pace_q == 8'd0);
`else
  logic [31:0] unused_gap_cycles;
  assign unused_gap_cycles = GAP_CYCLES;
  assign pace_ok = 1'b1;
`endif

  // Storage write: accepted push lands at the write pointer.
  always_comb begin
    mem_d = mem_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = push_ch;
    end
  end

  // Pointers, occupancy and saturating event counters.
  always_comb begin
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    level_d           = level_q;
    rd_count_d        = rd_count_q;
    underrun_count_d  = underrun_count_q;
    push_drop_count_d = push_drop_count_q;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_acc, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (pop && (rd_count_q != '1)) begin
      rd_count_d = rd_count_q + 32'd1;
    end
    if (uart_in_valid && !deliverable && (underrun_count_q != '1)) begin
      underrun_count_d = underrun_count_q + 32'd1;
    end
    if (push_valid && !push_ready && (push_drop_count_q != '1)) begin
      push_drop_count_d = push_drop_count_q + 16'd1;
    end
  end

  // Control state register; reset discards FIFO contents by clearing pointers and level.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      level_q           <= '0;
      rd_count_q        <= '0;
      underrun_count_q  <= '0;
      push_drop_count_q <= '0;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      level_q           <= level_d;
      rd_count_q        <= rd_count_d;
      underrun_count_q  <= underrun_count_d;
      push_drop_count_q <= push_drop_count_d;
    end
  end

  // Storage array; contents need no reset since level gates visibility.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_sim_uart_in_feeder.sv
// Directed bench for sim_uart_in_feeder: push/strobe ordering, underruns, full/drop, reset, pacing, saturation.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
// The pacing scenario runs only when UART_IN_PACING_EN is defined (GAP_CYCLES = 4).
module tb_sim_uart_in_feeder;

  logic        clock = 1'b0;
  logic        reset;
  logic        push_valid;
  logic [7:0]  push_ch;
  logic        push_ready;
  logic        uart_in_valid;
  logic [7:0]  uart_in_ch;
  logic [4:0]  level;
  logic [31:0] rd_count;
  logic [31:0] underrun_count;
  logic [15:0] push_drop_count;

  int vectors     = 0;
  int miscompares = 0;

  sim_uart_in_feeder #(
    .DEPTH      (16),
    .EMPTY_CHAR (8'hff),
    .GAP_CYCLES (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .push_valid      (push_valid),
    .push_ch         (push_ch),
    .push_ready      (push_ready),
    .uart_in_valid   (uart_in_valid),
    .uart_in_ch      (uart_in_ch),
    .level           (level),
    .rd_count        (rd_count),
    .underrun_count  (underrun_count),
    .push_drop_count (push_drop_count)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b0;
    push_valid = 1'b0;
    uart_in_valid = 1'b0;
    push_ch = 8'h00;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic push_n(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      push_valid = 1'b1;
      push_ch    = first + 8'(i);
      tick();
    end
    push_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_push_ready", 32'(push_ready), 32'd1);
    check("rst_ch", 32'(uart_in_ch), 32'hff);
    check("rst_level", 32'(level), 32'd0);
    check("rst_rd", rd_count, 32'd0);
    check("rst_underrun", underrun_count, 32'd0);
    check("rst_drop", 32'(push_drop_count), 32'd0);

`ifdef UART_IN_PACING_EN
    // Three chars, strobe every cycle: deliveries at cycles 0, 5, 10.
    push_n(8'h31, 3);
    check("pace_level", 32'(level), 32'd3);
    uart_in_valid = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      logic [7:0] exp_ch;
      exp_ch = (k == 0) ? 8'h31 : (k == 5) ? 8'h32 : (k == 10) ? 8'h33 : 8'hff;
      #1;
      check($sformatf("pace_ch_c%0d", k), 32'(uart_in_ch), 32'(exp_ch));
      tick();
    end
    uart_in_valid = 1'b0;
    #1;
    check("pace_underrun", underrun_count, 32'd8);
    check("pace_rd", rd_count, 32'd3);
    check("pace_level_end", 32'(level), 32'd0);
`else
    // Push A,B,C then read them back-to-back.
    push_n(8'h41, 3);
    check("abc_level", 32'(level), 32'd3);
    uart_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("abc_ch%0d", k), 32'(uart_in_ch), 32'(8'h41 + 8'(k)));
      tick();
    end
    uart_in_valid = 1'b0;
    #1;
    check("abc_rd", rd_count, 32'd3);
    check("abc_level_end", 32'(level), 32'd0);
    check("abc_underrun", underrun_count, 32'd0);

    // Strobe on empty, then push with a same-cycle strobe.
    uart_in_valid = 1'b1;
    #1;
    check("empty_ch", 32'(uart_in_ch), 32'hff);
    tick();
    push_valid = 1'b1;
    push_ch    = 8'h5a;
    #1;
    check("push_strobe_ch", 32'(uart_in_ch), 32'hff);
    tick();
    push_valid = 1'b0;
    #1;
    check("next_cycle_ch", 32'(uart_in_ch), 32'h5a);
    tick();
    uart_in_valid = 1'b0;
    #1;
    check("empty_underrun", underrun_count, 32'd2);
    check("empty_rd", rd_count, 32'd4);

    // Fill with F0..FF (FF is a real char), then two refused pushes.
    push_n(8'hf0, 16);
    #1;
    check("full_ready", 32'(push_ready), 32'd0);
    check("full_level", 32'(level), 32'd16);
    push_n(8'h10, 2);
    #1;
    check("full_drop", 32'(push_drop_count), 32'd2);
    check("full_level2", 32'(level), 32'd16);
    // Full with push+pop in the same cycle: pop wins, push is refused.
    push_valid    = 1'b1;
    push_ch       = 8'h77;
    uart_in_valid = 1'b1;
    #1;
    check("full_pp_ch", 32'(uart_in_ch), 32'hf0);
    tick();
    push_valid = 1'b0;
    #1;
    check("full_pp_drop", 32'(push_drop_count), 32'd3);
    check("full_pp_level", 32'(level), 32'd15);
    for (int k = 1; k < 16; k++) begin
      check($sformatf("drain_ch%0d", k), 32'(uart_in_ch), 32'(8'hf0 + 8'(k)));
      tick();
      #1;
    end
    uart_in_valid = 1'b0;
    check("drain_rd", rd_count, 32'd20);
    check("drain_level", 32'(level), 32'd0);

    // Level 5, reset for one cycle with a push and strobe pending.
    push_n(8'h21, 5);
    check("pre_rst_level", 32'(level), 32'd5);
    reset         = 1'b0;
    push_valid    = 1'b1;
    push_ch       = 8'h99;
    uart_in_valid = 1'b1;
    tick();
    reset      = 1'b1;
    push_valid = 1'b0;
    #1;
    check("mid_rst_ch", 32'(uart_in_ch), 32'hff);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_rd", rd_count, 32'd0);
    check("mid_rst_underrun", underrun_count, 32'd0);
    check("mid_rst_drop", 32'(push_drop_count), 32'd0);
    check("mid_rst_ready", 32'(push_ready), 32'd1);
    tick();
    uart_in_valid = 1'b0;
    #1;
    check("post_rst_underrun", underrun_count, 32'd1);

    // Saturation of rd_count.
    do_reset();
    push_n(8'h61, 3);
    force dut.rd_count_q = 32'hffff_fffe;
    #1;
    release dut.rd_count_q;
    #1;
    check("sat_preload", rd_count, 32'hffff_fffe);
    uart_in_valid = 1'b1;
    tick();
    #1;
    check("sat_rd1", rd_count, 32'hffff_ffff);
    tick();
    tick();
    uart_in_valid = 1'b0;
    #1;
    check("sat_rd3", rd_count, 32'hffff_ffff);
    check("sat_level", 32'(level), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sim_uart_in_feeder.md
# sim_uart_in_feeder

Simulation-side UART input source for the `SimTop` `io_uart_in_*` interface. It is the receive-path counterpart of the UART output printer. The host side (DPI or stimulus file reader) pushes characters into an internal FIFO. The DUT pulls one character per read strobe on `uart_in_valid` and receives `uart_in_ch` in the same cycle. When no character is available, the block returns the idle code `8'hff`, as the constant tie-off did before it.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `EMPTY_CHAR`, 8'hff: value returned when no character is deliverable.
- `GAP_CYCLES`, 8: minimum cycles between deliveries; used only with `UART_IN_PACING_EN`; range 1..255.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `push_valid`  in  1  host offers `push_ch` this cycle.
- `push_ch`  in  8  character from host.
- `push_ready`  out  1  FIFO not full; a push is accepted when `push_valid && push_ready`.
- `uart_in_valid`  in  1  DUT read strobe; one read per high cycle.
- `uart_in_ch`  out  8  character returned to the DUT, valid in the cycle of the strobe.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `rd_count`  out  32  characters delivered to the DUT; saturating.
- `underrun_count`  out  32  strobes that received `EMPTY_CHAR`; saturating.
- `push_drop_count`  out  16  cycles with `push_valid && !push_ready`; saturating.

## Operation
- FIFO state:
  - circular buffer of `DEPTH`×8;
  - read and write pointers are `$clog2(DEPTH)` bits, wrap naturally;
  - `level` is tracked as an explicit counter.
- `deliverable` = (`level != 0`) && pace_ok. Without pacing, pace_ok is 1.
- `uart_in_ch` is combinational:
  - the FIFO head when `deliverable`;
  - `EMPTY_CHAR` otherwise.
  - This holds regardless of `uart_in_valid`.
- Strobe with `deliverable`:
  - pop on the clock edge;
  - `rd_count` +1.
- Strobe without `deliverable`:
  - no pop;
  - `underrun_count` +1.
- Push:
  - accepted when `push_valid && push_ready`;
  - writes at the write pointer; the pointer advances.
  - `push_ready = (level != DEPTH)`. It depends only on the registered level, not on a same-cycle pop.
- Level update:
  - push only: +1;
  - pop only: −1;
  - both: unchanged.
- Push into an empty FIFO: the character is not visible in the same cycle. A same-cycle strobe returns `EMPTY_CHAR` and counts as an underrun; the character is deliverable next cycle.
- Full FIFO with simultaneous push and pop: the pop occurs and the push is refused. `push_drop_count` +1; the host retries.
- All counters saturate at all-ones and never wrap.
- A pushed value of `8'hff` is a legal character: it is stored and counted as delivered, even though it looks like idle to the DUT.

## Timing
- Reset (`reset == 0` at a rising edge) clears:
  - both pointers, `level`, and all counters to 0;
  - the pace counter to 0.
- Outputs after reset: `push_ready = 1`, `uart_in_ch = EMPTY_CHAR`, `level = 0`, all counts 0.
- Reset asserted mid-operation discards FIFO contents immediately at that edge. A push or strobe in the same cycle as reset has no effect.
- Read latency is 0 cycles (strobe-to-data combinational); pop takes effect at the strobe-cycle edge. Back-to-back strobes on consecutive cycles deliver consecutive FIFO entries.
- Push-to-deliverable latency is 1 cycle.
- `level` and the counters are registered; they update at the edge ending the event cycle.

## Configuration
- `UART_IN_PACING_EN` defined:
  - an 8-bit pace counter is loaded with `GAP_CYCLES` on every successful pop;
  - it decrements by 1 per cycle while nonzero;
  - pace_ok = (pace counter == 0).
  - A strobe while pace_ok = 0 returns `EMPTY_CHAR`, does not pop, and increments `underrun_count`. This emulates a finite baud rate.
  - After a pop at edge N, the next delivery is possible in the cycle after edge N+`GAP_CYCLES`.
- `UART_IN_PACING_EN` undefined: no pace counter; pace_ok ≡ 1; `GAP_CYCLES` is ignored.

## Test plan
- After reset: push 'A','B','C' (8'h41–43) on 3 consecutive cycles, then 3 consecutive strobes. Required: `uart_in_ch` = 41,42,43; `rd_count` = 3; `level` = 0; `underrun_count` = 0.
- Strobe on an empty FIFO, and a push with a same-cycle strobe. Required: both strobes return 8'hff; `underrun_count` = 2; the pushed char is delivered on the next-cycle strobe.
- Push `DEPTH`+2 chars with no strobes. Required: `push_ready` = 0 after 16 pushes; `push_drop_count` = 2; `level` = 16. Drain 16 strobes and check order.
- Hold `level` = 5, assert reset for 1 cycle, then strobe. Required: 8'hff; all counters 0; `push_ready` = 1.
- Pacing build with `GAP_CYCLES` = 4, FIFO holding 3 chars, strobe every cycle. Required:
  - deliveries on cycles 0, 5, 10;
  - the 8 strobes in between return 8'hff;
  - `underrun_count` = 8.
- Saturation: force `rd_count` to 32'hffff_fffe, then 3 strobes with data. Required: ends at 32'hffff_ffff.
